// File: rtl/otn_tx_sched.sv
// otn_tx_sched: transmit frame scheduler for a 4 x NUM_COLS frame.
// Optional macro FEC_COLS_EN reserves the last FEC_COLS columns of each row for parity.
module otn_tx_sched #(
    parameter int NUM_COLS      = 1040,
    parameter int OH_COLS       = 16,
    parameter int PLD_START_LVL = 64,
    parameter int FEC_COLS      = 16,
    parameter int LVL_W         = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [1:0]       i_row_cnt,
    input  logic [10:0]      i_col_cnt,
    input  logic [LVL_W-1:0] i_pld_level,
    input  logic             i_pld_empty,
    output logic             o_fpc_valid,
    output logic             o_oh_rd,
    output logic             o_pld_rd,
    output logic [1:0]       o_sel,
    output logic             o_sof,
    output logic             o_busy,
    output logic             o_underrun,
    output logic [15:0]      o_frame_cnt
);

    localparam logic [10:0]      COL_LIMIT = 11'(NUM_COLS);
    localparam logic [10:0]      LAST_COL  = 11'(NUM_COLS - 1);
    localparam logic [10:0]      OH_END    = 11'(OH_COLS);
    localparam logic [LVL_W-1:0] START_LVL = LVL_W'(PLD_START_LVL);
`ifdef FEC_COLS_EN
    localparam logic [10:0]      PAR_START = 11'(NUM_COLS - FEC_COLS);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   active;
    logic   eof;
    logic   slot_empty;

    assign active = (state == RUN) || (state == DRAIN);
    assign eof    = active && (i_row_cnt == 2'd3) && (i_col_cnt == LAST_COL);

    // State register; reset abandons any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start only with enough payload, always finish a started frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_enable) state_nxt = ARM;
            end
            ARM: begin
                if (!i_enable)                     state_nxt = IDLE;
                else if (i_pld_level >= START_LVL) state_nxt = RUN;
            end
            RUN: begin
                if (eof)            state_nxt = i_enable ? RUN : IDLE;
                else if (!i_enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (eof) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state and current frame position.
    always_comb begin
        o_sel       = 2'd0;
        o_oh_rd     = 1'b0;
        o_pld_rd    = 1'b0;
        slot_empty  = 1'b0;
        o_fpc_valid = active;
        o_busy      = (state != IDLE);
        o_sof       = active && (i_row_cnt == 2'd0) && (i_col_cnt == 11'd0);
        if (active) begin
            if (i_col_cnt >= COL_LIMIT) begin
                o_sel = 2'd0;
            end else if (i_col_cnt < OH_END) begin
                o_sel   = 2'd1;
                o_oh_rd = 1'b1;
`ifdef FEC_COLS_EN
            end else if (i_col_cnt >= PAR_START) begin
                o_sel = 2'd3;
`endif
            end else if (!i_pld_empty) begin
                o_sel    = 2'd2;
                o_pld_rd = 1'b1;
            end else begin
                slot_empty = 1'b1;
            end
        end
    end

    // Underrun flag follows each starved payload slot by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= slot_empty;
        end
    end

    // Completed-frame counter, free-running wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_cnt <= 16'd0;
        end else if (eof) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_otn_tx_sched.sv
// tb_otn_tx_sched: directed bench with a position-counter model
// and an underrun scoreboard queue.
module tb_otn_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  row;
    logic [10:0] col;
    logic [10:0] level;
    logic        pld_empty;
    logic        fpc_valid;
    logic        oh_rd;
    logic        pld_rd;
    logic [1:0]  sel;
    logic        sof;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    logic ur_q[$];
    int   exp_frames = 0;
    logic en_level = 1'b0;
    int   drop_at = -1;
    logic win_on = 1'b0;
    logic chk_rows = 1'b0;
    int   n_fpc = 0;
    int   row_oh = 0;
    int   row_pld = 0;

    always #5 clk = ~clk;

    otn_tx_sched dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .i_row_cnt   (row),
        .i_col_cnt   (col),
        .i_pld_level (level),
        .i_pld_empty (pld_empty),
        .o_fpc_valid (fpc_valid),
        .o_oh_rd     (oh_rd),
        .o_pld_rd    (pld_rd),
        .o_sel       (sel),
        .o_sof       (sof),
        .o_busy      (busy),
        .o_underrun  (underrun),
        .o_frame_cnt (frame_cnt)
    );

    // Frame position counter model sharing the scheduler reset.
    always @(posedge clk) begin
        if (rst) begin
            row <= 2'd0;
            col <= 11'd0;
        end else if (fpc_valid) begin
            if (col == 11'd1039) begin
                col <= 11'd0;
                row <= row + 2'd1;
            end else begin
                col <= col + 11'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pop_ur();
        logic v;
        v = 1'b0;
        if (ur_q.size() > 0) v = ur_q.pop_front();
        return v;
    endfunction

    // One cycle while the scheduler is expected to be outside RUN/DRAIN.
    task automatic other_cyc(input logic en, input logic exp_busy);
        @(negedge clk);
        enable    = en;
        pld_empty = 1'b0;
        #1;
        check("fpc_valid_off", fpc_valid, 0);
        check("sel_off", sel, 0);
        check("oh_rd_off", oh_rd, 0);
        check("pld_rd_off", pld_rd, 0);
        check("sof_off", sof, 0);
        check("busy_off", busy, exp_busy);
        check("underrun_off", underrun, pop_ur());
        check("frame_cnt_off", frame_cnt, exp_frames);
        ur_q.push_back(1'b0);
    endtask

    // One cycle while the scheduler is expected to be in RUN/DRAIN.
    task automatic run_cyc();
        int   pos;
        logic fec;
        logic pay;
        logic [1:0] es;
        @(negedge clk);
        pos = int'(row) * 1040 + int'(col);
        if (pos == drop_at) en_level = 1'b0;
        enable    = en_level;
        pld_empty = win_on && ((row == 2'd1 && col >= 11'd500 && col <= 11'd502) ||
                               (row == 2'd3 && col >= 11'd1030 && col <= 11'd1035));
        #1;
        fec = 1'b0;
`ifdef FEC_COLS_EN
        fec = (col >= 11'd1024);
`endif
        pay = (col >= 11'd16) && !fec;
        if (col < 11'd16)          es = 2'd1;
        else if (fec)              es = 2'd3;
        else if (!pld_empty)       es = 2'd2;
        else                       es = 2'd0;
        check("fpc_valid", fpc_valid, 1);
        check("busy", busy, 1);
        check("sel", sel, es);
        check("oh_rd", oh_rd, col < 11'd16);
        check("pld_rd", pld_rd, pay && !pld_empty);
        check("sof", sof, row == 2'd0 && col == 11'd0);
        check("underrun", underrun, pop_ur());
        check("frame_cnt", frame_cnt, exp_frames);
        ur_q.push_back(pay && pld_empty);
        n_fpc   += int'(fpc_valid);
        row_oh  += int'(oh_rd);
        row_pld += int'(pld_rd);
        if (chk_rows && col == 11'd1039) begin
            check("row_oh_count", row_oh, 16);
`ifdef FEC_COLS_EN
            check("row_pld_count", row_pld, 1008);
`else
            check("row_pld_count", row_pld, 1024);
`endif
            row_oh  = 0;
            row_pld = 0;
        end
        if (row == 2'd3 && col == 11'd1039) exp_frames++;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        level     = 11'd0;
        pld_empty = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_fpc_valid", fpc_valid, 0);
        check("rst_sel", sel, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        ur_q.push_back(1'b0);

        level = 11'd63;
        other_cyc(1'b1, 1'b0);
        repeat (5) other_cyc(1'b1, 1'b1);
        level = 11'd64;

        en_level = 1'b1;
        chk_rows = 1'b1;
        n_fpc    = 0;
        repeat (4160) run_cyc();
        check("frame1_fpc_cycles", n_fpc, 4160);
        chk_rows = 1'b0;

        win_on  = 1'b1;
        drop_at = 2 * 1040 + 100;
        repeat (4160) run_cyc();
        win_on = 1'b0;
        other_cyc(1'b0, 1'b0);
        check("drain_frame_cnt", frame_cnt, 2);
        check("drain_row", row, 0);
        check("drain_col", col, 0);

        other_cyc(1'b1, 1'b0);
        other_cyc(1'b1, 1'b1);
        en_level = 1'b1;
        drop_at  = 3 * 1040 + 1039;
        repeat (4160) run_cyc();
        other_cyc(1'b0, 1'b0);
        check("lastcol_frame_cnt", frame_cnt, 3);

        other_cyc(1'b1, 1'b0);
        other_cyc(1'b1, 1'b1);
        en_level = 1'b1;
        drop_at  = -1;
        repeat (1040 + 700) run_cyc();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_frames = 0;
        check("mrst_busy", busy, 0);
        check("mrst_fpc_valid", fpc_valid, 0);
        check("mrst_sel", sel, 0);
        check("mrst_oh_rd", oh_rd, 0);
        check("mrst_pld_rd", pld_rd, 0);
        check("mrst_underrun", underrun, 0);
        check("mrst_frame_cnt", frame_cnt, 0);
        check("mrst_row", row, 0);
        check("mrst_col", col, 0);
        ur_q.delete();
        ur_q.push_back(1'b0);
        other_cyc(1'b1, 1'b1);
        repeat (20) run_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
